// File: rtl/sprite_pixel_scheduler.sv
// Resolves one screen pixel against four prioritised 32x32 sprites, fetching
// texels through a shared synchronous ROM and skipping transparent ones.
module sprite_pixel_scheduler #(
  parameter logic [3:0] TRANSP_IDX = 4'h2,
  parameter logic [3:0] BG_IDX     = 4'h7
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        pix_req,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [3:0]  spr_en,
  input  logic [39:0] spr_x,
  input  logic [39:0] spr_y,
  output logic [11:0] rom_addr,
  input  logic [3:0]  rom_data,
  output logic [3:0]  palette_index,
  output logic        pix_valid,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    FETCH = 3'd2,
    EVAL  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      r_state;
  logic [1:0]  r_cur;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [11:0] r_rom_addr;
  logic [3:0]  r_palette;
  logic        r_valid;
  logic        r_busy;
  logic        r_overrun;

  logic        w_en;
  logic [9:0]  w_sx;
  logic [9:0]  w_sy;
  logic        w_cover;
  logic [4:0]  w_dx;
  logic [4:0]  w_dy;

  // Live selection of the sprite currently being examined
  always_comb begin
    w_en = 1'b0;
    w_sx = 10'd0;
    w_sy = 10'd0;
    case (r_cur)
      2'd0:    begin w_en = spr_en[0]; w_sx = spr_x[9:0];   w_sy = spr_y[9:0];   end
      2'd1:    begin w_en = spr_en[1]; w_sx = spr_x[19:10]; w_sy = spr_y[19:10]; end
      2'd2:    begin w_en = spr_en[2]; w_sx = spr_x[29:20]; w_sy = spr_y[29:20]; end
      2'd3:    begin w_en = spr_en[3]; w_sx = spr_x[39:30]; w_sy = spr_y[39:30]; end
      default: begin w_en = 1'b0;      w_sx = 10'd0;        w_sy = 10'd0;        end
    endcase
  end

  // Bounds are widened to 11 bits so sprites near the right/bottom edge never wrap
  assign w_cover = w_en
                && ({1'b0, r_x} >= {1'b0, w_sx}) && ({1'b0, r_x} <= ({1'b0, w_sx} + 11'd31))
                && ({1'b0, r_y} >= {1'b0, w_sy}) && ({1'b0, r_y} <= ({1'b0, w_sy} + 11'd31));
  assign w_dx = r_x[4:0] - w_sx[4:0];
  assign w_dy = r_y[4:0] - w_sy[4:0];

  // Resolution FSM with all outputs registered
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_cur      <= 2'd0;
      r_x        <= 10'd0;
      r_y        <= 10'd0;
      r_rom_addr <= 12'h000;
      r_palette  <= BG_IDX;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (pix_req && r_busy) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (pix_req) begin
            r_x     <= DrawX;
            r_y     <= DrawY;
            r_cur   <= 2'd0;
            r_busy  <= 1'b1;
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (w_cover) begin
            r_rom_addr <= {r_cur, w_dy, w_dx};
            r_state    <= FETCH;
          end else if (r_cur == 2'd3) begin
            r_palette <= BG_IDX;
            r_valid   <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_cur <= r_cur + 2'd1;
          end
        end
        FETCH: begin
          r_rom_addr <= 12'h000;
          r_state    <= EVAL;
        end
        EVAL: begin
          if (rom_data != TRANSP_IDX) begin
            r_palette <= rom_data;
            r_valid   <= 1'b1;
            r_state   <= DONE;
          end else if (r_cur == 2'd3) begin
            r_palette <= BG_IDX;
            r_valid   <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_cur   <= r_cur + 2'd1;
            r_state <= CHECK;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_rom_addr <= 12'h000;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign rom_addr      = r_rom_addr;
  assign palette_index = r_palette;
  assign pix_valid     = r_valid;
  assign busy          = r_busy;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_sprite_pixel_scheduler.sv
// Randomised and directed bench for sprite_pixel_scheduler, scored against a
// cycle-budget model of sprite priority, transparency and ROM addressing.
module tb_sprite_pixel_scheduler;

  localparam logic [3:0] TR = 4'h2;
  localparam logic [3:0] BG = 4'h7;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        pix_req;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [3:0]  spr_en;
  logic [39:0] spr_x;
  logic [39:0] spr_y;
  logic [11:0] rom_addr;
  logic [3:0]  rom_data;
  logic [3:0]  palette_index;
  logic        pix_valid;
  logic        busy;
  logic        overrun;

  sprite_pixel_scheduler #(.TRANSP_IDX(TR), .BG_IDX(BG)) dut (
    .Clk(Clk), .Reset(Reset), .pix_req(pix_req), .DrawX(DrawX), .DrawY(DrawY),
    .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y), .rom_addr(rom_addr),
    .rom_data(rom_data), .palette_index(palette_index), .pix_valid(pix_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  // Synchronous sprite ROM: data follows the address by one cycle
  logic [3:0] rom_mem [0:4095];
  always @(posedge Clk) rom_data <= rom_mem[rom_addr];

  int n_vec = 0;
  int n_err = 0;
  int sx [4];
  int sy [4];
  logic [11:0] m_addr [0:19];
  int          m_vc;
  logic [3:0]  m_res;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_sprites(input logic [3:0] en);
    spr_en = en;
    for (int i = 0; i < 4; i++) begin
      spr_x[i*10 +: 10] = sx[i][9:0];
      spr_y[i*10 +: 10] = sy[i][9:0];
    end
  endtask

  // Reference: walk sprites by priority, charging 1 cycle per skip and 3 per fetch
  task automatic model(input int x, input int y);
    int c;
    logic [11:0] a;
    logic [1:0] id;
    for (int k = 0; k < 20; k++) m_addr[k] = 12'h000;
    c = 1;
    m_res = BG;
    for (int i = 0; i < 4; i++) begin
      if (spr_en[i] && sx[i] <= x && x <= sx[i] + 31 && sy[i] <= y && y <= sy[i] + 31) begin
        id = i[1:0];
        a = {id, 5'(y - sy[i]), 5'(x - sx[i])};
        m_addr[c+1] = a;
        c += 3;
        if (rom_mem[a] != TR) begin
          m_res = rom_mem[a];
          m_vc = c;
          return;
        end
      end else begin
        c += 1;
      end
    end
    m_vc = c;
  endtask

  task automatic resolve(input int x, input int y, input int dup);
    model(x, y);
    @(negedge Clk);
    check("idle_busy", 32'(busy), 32'd0);
    pix_req = 1'b1;
    DrawX = x[9:0];
    DrawY = y[9:0];
    for (int c = 1; c <= m_vc; c++) begin
      @(negedge Clk);
      if (c == dup) begin
        pix_req = 1'b1;
        DrawX = ~DrawX;
        DrawY = ~DrawY;
      end else begin
        pix_req = 1'b0;
      end
      check("rom_addr", 32'(rom_addr), 32'(m_addr[c]));
      check("pix_valid", 32'(pix_valid), 32'(c == m_vc));
      check("busy", 32'(busy), 32'd1);
      if (c == m_vc) check("palette", 32'(palette_index), 32'(m_res));
    end
    @(negedge Clk);
    pix_req = 1'b0;
    check("post_valid", 32'(pix_valid), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_hold", 32'(palette_index), 32'(m_res));
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    logic [11:0] a;
    int x, y;
    Reset = 1'b1; pix_req = 1'b0; DrawX = 10'd0; DrawY = 10'd0;
    spr_en = 4'd0; spr_x = 40'd0; spr_y = 40'd0;
    for (int i = 0; i < 4096; i++)
      rom_mem[i] = (($urandom % 4) == 0) ? TR : 4'($urandom);
    for (int i = 0; i < 4; i++) begin sx[i] = 0; sy[i] = 0; end
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    check("rst_palette", 32'(palette_index), 32'(BG));
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);

    // Single covering sprite with opaque texel
    sx[0] = 100; sy[0] = 50;
    set_sprites(4'b0001);
    a = {2'd0, 5'd10, 5'd5};
    rom_mem[a] = 4'h5;
    resolve(105, 60, 0);
    check("d1_palette", 32'(palette_index), 32'h5);
    check("d1_latency", 32'(m_vc), 32'd4);

    // No sprites enabled
    set_sprites(4'b0000);
    resolve(0, 0, 0);
    check("d2_palette", 32'(palette_index), 32'(BG));
    check("d2_latency", 32'(m_vc), 32'd5);

    // Transparent top sprite reveals the one underneath
    sx[0] = 190; sy[0] = 195; sx[1] = 180; sy[1] = 170;
    set_sprites(4'b0011);
    a = {2'd0, 5'd5, 5'd10};  rom_mem[a] = TR;
    a = {2'd1, 5'd30, 5'd20}; rom_mem[a] = 4'hA;
    resolve(200, 200, 0);
    check("d3_palette", 32'(palette_index), 32'hA);
    check("d3_latency", 32'(m_vc), 32'd7);

    // Right-edge sprite must not wrap around to low columns
    sx[3] = 1000; sy[3] = 300;
    set_sprites(4'b1000);
    a = {2'd3, 5'd10, 5'd23}; rom_mem[a] = 4'hC;
    resolve(1023, 310, 0);
    check("d4_palette", 32'(palette_index), 32'hC);
    resolve(5, 310, 0);
    check("d4_nowrap", 32'(palette_index), 32'(BG));

    // Random scenes clustered around the pixel so sprites often overlap it
    for (int t = 0; t < 60; t++) begin
      x = int'($urandom_range(0, 1023));
      y = int'($urandom_range(0, 1023));
      for (int i = 0; i < 4; i++) begin
        sx[i] = x - int'($urandom_range(0, 40)); if (sx[i] < 0) sx[i] = 0;
        sy[i] = y - int'($urandom_range(0, 40)); if (sy[i] < 0) sy[i] = 0;
      end
      set_sprites(4'($urandom));
      resolve(x, y, 0);
    end
    check("rand_overrun", 32'(overrun), 32'd0);

    // Request while busy is dropped and flagged
    sx[0] = 100; sy[0] = 50;
    set_sprites(4'b0001);
    resolve(105, 60, 1);
    check("ovr_palette", 32'(palette_index), 32'h5);
    check("ovr_flag", 32'(overrun), 32'd1);
    do_reset();
    check("ovr_cleared", 32'(overrun), 32'd0);

    // Reset during FETCH aborts the resolution
    @(negedge Clk);
    pix_req = 1'b1; DrawX = 10'd105; DrawY = 10'd60;
    @(negedge Clk);
    pix_req = 1'b0;
    @(negedge Clk);
    a = {2'd0, 5'd10, 5'd5};
    check("abort_fetch", 32'(rom_addr), 32'(a));
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(pix_valid), 32'd0);
    check("abort_palette", 32'(palette_index), 32'(BG));
    check("abort_addr", 32'(rom_addr), 32'd0);
    resolve(105, 60, 0);
    check("abort_resume", 32'(palette_index), 32'h5);

    // Request coinciding with reset is discarded
    @(negedge Clk);
    Reset = 1'b1; pix_req = 1'b1;
    @(negedge Clk);
    Reset = 1'b0; pix_req = 1'b0;
    @(negedge Clk);
    check("rstreq_busy", 32'(busy), 32'd0);
    check("rstreq_overrun", 32'(overrun), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
